// File: rtl/be8_sequencer_if.sv
// Signal bundle between the BE-8 sequencer and its microcode decoder / datapath.
// The master side drives control and status into the sequencer; the slave side is the sequencer.
interface be8_sequencer_if;
    logic [17:0] ctrl;
    logic [7:0]  bus_in;
    logic        alu_carry;
    logic        alu_zero;
    logic        run;
    logic        step_req;
    logic [3:0]  opcode;
    logic [1:0]  flags;
    logic [1:0]  step;
    logic [7:0]  bus_out;
    logic        bus_oe;
    logic [3:0]  pc;
    logic        halted;
    logic        bus_err;
    logic [7:0]  instr_count;

    modport master (
        output ctrl, bus_in, alu_carry, alu_zero, run, step_req,
        input  opcode, flags, step, bus_out, bus_oe, pc, halted, bus_err, instr_count
    );

    modport slave (
        input  ctrl, bus_in, alu_carry, alu_zero, run, step_req,
        output opcode, flags, step, bus_out, bus_oe, pc, halted, bus_err, instr_count
    );
endinterface

// File: rtl/be8_sequencer.sv
// BE-8 microcode sequencer: step counter, PC, IR, flags, halt, bus-contention and instruction count.
// Optional macro BE8_SINGLE_STEP_EN adds a rising-edge single-step request alongside run.
module be8_sequencer (
    input  logic             clk,
    input  logic             rst,
    be8_sequencer_if.slave   sif
);
    localparam int HLT = 17;
    localparam int CE  = 16;
    localparam int IIN = 11;
    localparam int JN  = 10;
    localparam int FIN = 9;
    localparam int COK = 3;
    localparam int ION = 4;
    localparam int NON = 0;

    logic [1:0] step_q, step_d;
    logic [3:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [1:0] flags_q, flags_d;
    logic       halted_q, halted_d;
    logic       bus_err_q, bus_err_d;
    logic [7:0] cnt_q, cnt_d;
    logic       go;
    logic       advance;
    logic       contention;

`ifdef BE8_SINGLE_STEP_EN
    logic step_req_q;

    // The request register samples every cycle so edge detection stays valid while idle.
    always_ff @(posedge clk) begin
        if (rst) step_req_q <= 1'b0;
        else     step_req_q <= sif.step_req;
    end

    assign go = sif.run | (sif.step_req & ~step_req_q);
`else
    assign go = sif.run;
`endif

    assign advance    = ~halted_q & go;
    // Active-low bus drivers: AOn, BOn, IOn, COn, EOn, ROn occupy ctrl[6:1].
    assign contention = ($countones(~sif.ctrl[6:1]) > 1);

    always_comb begin
        step_d    = step_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        flags_d   = flags_q;
        halted_d  = halted_q;
        bus_err_d = bus_err_q;
        cnt_d     = cnt_q;
        if (advance) begin
            if (sif.ctrl[HLT])       halted_d = 1'b1;
            else if (!sif.ctrl[NON]) step_d   = 2'd0;
            else                     step_d   = step_q + 2'd1;

            if (!sif.ctrl[JN])      pc_d = sif.bus_in[3:0];
            else if (sif.ctrl[CE])  pc_d = pc_q + 4'd1;

            if (!sif.ctrl[IIN]) ir_d    = sif.bus_in;
            if (!sif.ctrl[FIN]) flags_d = {sif.alu_carry, sif.alu_zero};
            if (contention)     bus_err_d = 1'b1;

            if (!sif.ctrl[NON] && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q    <= 2'd0;
            pc_q      <= 4'd0;
            ir_q      <= 8'd0;
            flags_q   <= 2'd0;
            halted_q  <= 1'b0;
            bus_err_q <= 1'b0;
            cnt_q     <= 8'd0;
        end else begin
            step_q    <= step_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            flags_q   <= flags_d;
            halted_q  <= halted_d;
            bus_err_q <= bus_err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign sif.opcode      = ir_q[7:4];
    assign sif.flags       = flags_q;
    assign sif.step        = step_q;
    assign sif.pc          = pc_q;
    assign sif.halted      = halted_q;
    assign sif.bus_err     = bus_err_q;
    assign sif.instr_count = cnt_q;
    assign sif.bus_oe      = ~sif.ctrl[COK] | ~sif.ctrl[ION];
    assign sif.bus_out     = !sif.ctrl[COK] ? {4'h0, pc_q} :
                             !sif.ctrl[ION] ? {4'h0, ir_q[3:0]} : 8'h00;
endmodule

// File: tb/tb_be8_sequencer.sv
// Scoreboard bench for be8_sequencer: stimulus queues expected values, a negedge monitor compares.
module tb_be8_sequencer;
  localparam logic [17:0] IDLE = 18'h07F7F;
  localparam int HLT = 17, CE = 16, IIN = 11, JN = 10, FIN = 9;
  localparam int AON = 6, ION = 4, CON = 3, RON = 1, NON = 0;
  localparam int S_STEP = 0, S_PC = 1, S_OPC = 2, S_FLG = 3, S_HLT = 4;
  localparam int S_ERR = 5, S_CNT = 6, S_OE = 7, S_BOUT = 8;

  typedef struct {
    string name;
    int    sel;
    int    val;
    int    cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edges = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  exp_t e;
  logic [17:0] c;

  be8_sequencer_if sif();

  be8_sequencer dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  function automatic int obs(int sel);
    case (sel)
      S_STEP:  return int'(sif.step);
      S_PC:    return int'(sif.pc);
      S_OPC:   return int'(sif.opcode);
      S_FLG:   return int'(sif.flags);
      S_HLT:   return int'(sif.halted);
      S_ERR:   return int'(sif.bus_err);
      S_CNT:   return int'(sif.instr_count);
      S_OE:    return int'(sif.bus_oe);
      default: return int'(sif.bus_out);
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= edges) begin
      e = q.pop_front();
      total = total + 1;
      if (obs(e.sel) != e.val) begin
        bad = bad + 1;
        $display("FAIL %s: got %0h expected %0h (edge %0d)", e.name, obs(e.sel), e.val, edges);
      end
    end
  end

  task automatic chk(input string n, input int sel, input int v);
    exp_t x;
    x.name = n;
    x.sel  = sel;
    x.val  = v;
    x.cyc  = edges;
    q.push_back(x);
  endtask

  task automatic chk_now(input string n, input int sel, input int v);
    total = total + 1;
    if (obs(sel) != v) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h (immediate, edge %0d)", n, obs(sel), v, edges);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    sif.ctrl = IDLE; sif.bus_in = 8'h00; sif.alu_carry = 1'b0; sif.alu_zero = 1'b0;
    sif.run = 1'b0; sif.step_req = 1'b0;

    // Reset state
    rst = 1'b1; tick(); rst = 1'b0;
    chk_now("rst_step", S_STEP, 0); chk_now("rst_pc", S_PC, 0); chk_now("rst_opc", S_OPC, 0);
    chk_now("rst_flags", S_FLG, 0); chk_now("rst_halt", S_HLT, 0); chk_now("rst_err", S_ERR, 0);
    chk_now("rst_cnt", S_CNT, 0); chk_now("rst_oe", S_OE, 0); chk_now("rst_bout", S_BOUT, 0);

    // Step counter wraps with idle words
    sif.run = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick(); chk("step_seq", S_STEP, i % 4); chk("step_seq_pc", S_PC, 0);
    end
    sif.run = 1'b0; tick(); chk("no_run_step", S_STEP, 0);
    sif.run = 1'b1;

    // Jump priority over CE, then increment wrap
    c = IDLE; c[CE] = 1'b1; c[JN] = 1'b0; sif.ctrl = c; sif.bus_in = 8'h3A;
    tick(); chk("jump_pc", S_PC, 4'hA); chk("jump_step", S_STEP, 1);
    c = IDLE; c[JN] = 1'b0; sif.ctrl = c; sif.bus_in = 8'h0F;
    tick(); chk("jump_pcF", S_PC, 4'hF);
    c = IDLE; c[CE] = 1'b1; sif.ctrl = c;
    tick(); chk("pc_wrap", S_PC, 0);
    tick(); chk("pc_inc", S_PC, 1); chk("pc_inc_step", S_STEP, 0);

    // IR load and bus drive
    c = IDLE; c[IIN] = 1'b0; sif.ctrl = c; sif.bus_in = 8'h5C;
    tick(); chk("opcode", S_OPC, 5);
    c = IDLE; c[ION] = 1'b0; sif.ctrl = c;
    chk("io_oe", S_OE, 1); chk("io_bout", S_BOUT, 8'h0C);
    tick(); chk("single_drv_err", S_ERR, 0); chk("io_step", S_STEP, 2);
    sif.run = 1'b0;
    c = IDLE; c[ION] = 1'b0; c[CON] = 1'b0; sif.ctrl = c;
    chk("co_oe", S_OE, 1); chk("co_prio", S_BOUT, 8'h01);
    tick(); chk("idle_no_err", S_ERR, 0); chk("idle_step", S_STEP, 2);
    sif.run = 1'b1;

    // Flags load
    c = IDLE; c[FIN] = 1'b0; sif.ctrl = c; sif.alu_carry = 1'b1; sif.alu_zero = 1'b0;
    tick(); chk("flags_c", S_FLG, 2);
    sif.alu_carry = 1'b0; sif.alu_zero = 1'b1;
    tick(); chk("flags_z", S_FLG, 1);
    sif.ctrl = IDLE; sif.alu_carry = 1'b1; sif.alu_zero = 1'b0;
    tick(); chk("flags_hold", S_FLG, 1); chk("flags_step", S_STEP, 1);

    // Bus contention is sticky
    c = IDLE; c[AON] = 1'b0; c[RON] = 1'b0; sif.ctrl = c;
    tick(); chk("err_set", S_ERR, 1);
    sif.ctrl = IDLE;
    for (int i = 0; i < 10; i++) begin
      tick(); chk("err_sticky", S_ERR, 1);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    chk("err_rst", S_ERR, 0); chk("err_rst_flags", S_FLG, 0);
    chk("err_rst_opc", S_OPC, 0); chk("err_rst_pc", S_PC, 0);

    // Halt at step 2; same-word PC update applies
    tick(); tick(); chk("pre_halt_step", S_STEP, 2);
    c = IDLE; c[HLT] = 1'b1; c[CE] = 1'b1; sif.ctrl = c;
    tick(); chk("halt_set", S_HLT, 1); chk("halt_step", S_STEP, 2); chk("halt_pc", S_PC, 1);
    c = IDLE; c[CE] = 1'b1; c[JN] = 1'b0; c[NON] = 1'b0; sif.ctrl = c; sif.bus_in = 8'h09;
    for (int i = 0; i < 20; i++) begin
      tick(); chk("halted_step", S_STEP, 2); chk("halted_pc", S_PC, 1);
    end
    chk_now("halted_cnt", S_CNT, 0); chk_now("halted_still", S_HLT, 1);
    c = IDLE; c[HLT] = 1'b1; c[JN] = 1'b0; sif.ctrl = c; sif.bus_in = 8'h37;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("halt_rst", S_HLT, 0); chk("halt_rst_step", S_STEP, 0); chk("halt_rst_pc", S_PC, 0);

    // Instruction count saturates
    c = IDLE; c[NON] = 1'b0; sif.ctrl = c;
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (i == 1 || i == 254 || i == 255 || i == 256)
        chk("icount", S_CNT, (i > 255) ? 255 : i);
    end
    chk("non_step", S_STEP, 0);

    // Single-step request with run low
    rst = 1'b1; tick(); rst = 1'b0;
    sif.run = 1'b0; sif.ctrl = IDLE; sif.step_req = 1'b1;
`ifdef BE8_SINGLE_STEP_EN
    for (int i = 0; i < 5; i++) begin
      tick(); chk("sstep_once", S_STEP, 1);
    end
    sif.step_req = 1'b0; tick(); chk("sstep_low", S_STEP, 1);
    sif.step_req = 1'b1; tick(); chk("sstep_again", S_STEP, 2);
`else
    for (int i = 0; i < 5; i++) begin
      tick(); chk("sstep_ignored", S_STEP, 0);
    end
`endif
    sif.step_req = 1'b0;
    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
